// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the byte-store sequencer: FSM state encoding
// and the group geometry (three bytes per group, last complete group base).
package mem_seq_pkg;

  localparam int GRP_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    RD1   = 3'd2,
    RD2   = 3'd3,
    RD3   = 3'd4,
    VALID = 3'd5,
    DONE  = 3'd6
  } seq_state_t;

  // Base of the last group that fits entirely inside the store.
  function automatic int last_base(input int adr_w);
    return GRP_BYTES * ((1 << adr_w) / GRP_BYTES) - GRP_BYTES;
  endfunction

endpackage

// File: rtl/mem_seq_ctrl_if.sv
// Host/loader handshake plus RAM port bundle for mem_seq_ctrl.
// slave is the controller's view, master is the host/RAM side.
interface mem_seq_ctrl_if #(
  parameter int ADR_W = 6,
  parameter int DAT_W = 8
);
  logic               wr_req;
  logic [ADR_W-1:0]   wr_adr;
  logic [DAT_W-1:0]   wr_data;
  logic               wr_ack;
  logic               start;
  logic               forward;
  logic [3*DAT_W-1:0] cache;
  logic               cache_vld;
  logic [4:0]         grp_idx;
  logic               fin;
  logic               mem_en;
  logic               mem_we;
  logic [ADR_W-1:0]   mem_adr;
  logic [DAT_W-1:0]   mem_wdata;
  logic [DAT_W-1:0]   mem_rdata;

  modport slave (
    input  wr_req, wr_adr, wr_data, start, forward, mem_rdata,
    output wr_ack, cache, cache_vld, grp_idx, fin,
           mem_en, mem_we, mem_adr, mem_wdata
  );

  modport master (
    output wr_req, wr_adr, wr_data, start, forward, mem_rdata,
    input  wr_ack, cache, cache_vld, grp_idx, fin,
           mem_en, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/mem_port_mux.sv
// Combinational owner of the single RAM port: the reader wins while fetching,
// otherwise a pending loader write is granted in the same cycle.
module mem_port_mux #(
  parameter int ADR_W = 6,
  parameter int DAT_W = 8
) (
  input  logic             rst_i,
  input  logic             rd_own_i,
  input  logic [ADR_W-1:0] rd_adr_i,
  input  logic             wr_req_i,
  input  logic [ADR_W-1:0] wr_adr_i,
  input  logic [DAT_W-1:0] wr_data_i,
  output logic             wr_ack_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [ADR_W-1:0] mem_adr_o,
  output logic [DAT_W-1:0] mem_wdata_o
);

  // Grant and port select; everything is forced idle while reset is held.
  always_comb begin
    wr_ack_o    = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_adr_o   = '0;
    mem_wdata_o = '0;
    if (rst_i) begin
      wr_ack_o = 1'b0;
    end else if (rd_own_i) begin
      mem_en_o  = 1'b1;
      mem_adr_o = rd_adr_i;
    end else if (wr_req_i) begin
      wr_ack_o    = 1'b1;
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_adr_o   = wr_adr_i;
      mem_wdata_o = wr_data_i;
    end else begin
      mem_en_o = 1'b0;
    end
  end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Group reader and port arbiter for the 64x8 byte store: fetches three bytes
// per group into a 24-bit cache and lets the loader write whenever the port is free.
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int ADR_W = 6,
  parameter int DAT_W = 8
) (
  input logic           Clk,
  input logic           Rst,
  mem_seq_ctrl_if.slave bus
);

  localparam logic [ADR_W-1:0] LAST_BASE = ADR_W'(last_base(ADR_W));

  seq_state_t         state_q, state_d;
  logic [ADR_W-1:0]   base_q, base_d;
  logic [4:0]         grp_q, grp_d;
  logic [3*DAT_W-1:0] cache_q;
  logic               vld_q, fin_q;
  logic               restart_s;
  logic               rd_own_s;
  logic [ADR_W-1:0]   rd_adr_s;
  logic [2:0]         cap_s;

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and base/group counters; start is ignored while the reader owns the port.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    grp_d     = grp_q;
    restart_s = bus.start && !(state_q inside {RD0, RD1, RD2});
    if (restart_s) begin
      state_d = RD0;
      base_d  = '0;
      grp_d   = 5'd0;
    end else begin
      case (state_q)
        RD0:     state_d = RD1;
        RD1:     state_d = RD2;
        RD2:     state_d = RD3;
        RD3:     state_d = VALID;
        VALID: begin
          if (bus.forward && (base_q == LAST_BASE)) begin
            state_d = DONE;
          end else if (bus.forward) begin
            state_d = RD0;
            base_d  = base_q + ADR_W'(GRP_BYTES);
            grp_d   = grp_q + 5'd1;
          end else begin
            state_d = VALID;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Read address and byte-lane capture strobes (RAM data trails the address by one cycle).
  always_comb begin
    rd_own_s = 1'b0;
    rd_adr_s = base_q;
    cap_s    = 3'b000;
    case (state_q)
      RD0: rd_own_s = 1'b1;
      RD1: begin
        rd_own_s = 1'b1;
        rd_adr_s = base_q + ADR_W'(1);
        cap_s    = 3'b001;
      end
      RD2: begin
        rd_own_s = 1'b1;
        rd_adr_s = base_q + ADR_W'(2);
        cap_s    = 3'b010;
      end
      RD3:     cap_s = 3'b100;
      default: rd_own_s = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      base_q  <= '0;
      grp_q   <= 5'd0;
      cache_q <= '0;
      vld_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      base_q <= base_d;
      grp_q  <= grp_d;
      vld_q  <= (state_d == VALID);
      fin_q  <= (state_d == DONE);
      for (int i = 0; i < GRP_BYTES; i++) begin
        if (cap_s[i]) cache_q[i*DAT_W +: DAT_W] <= bus.mem_rdata;
      end
    end
  end

  assign bus.cache     = cache_q;
  assign bus.cache_vld = vld_q;
  assign bus.grp_idx   = grp_q;
  assign bus.fin       = fin_q;

  mem_port_mux #(.ADR_W(ADR_W), .DAT_W(DAT_W)) u_port_mux (
    .rst_i       (Rst),
    .rd_own_i    (rd_own_s),
    .rd_adr_i    (rd_adr_s),
    .wr_req_i    (bus.wr_req),
    .wr_adr_i    (bus.wr_adr),
    .wr_data_i   (bus.wr_data),
    .wr_ack_o    (bus.wr_ack),
    .mem_en_o    (bus.mem_en),
    .mem_we_o    (bus.mem_we),
    .mem_adr_o   (bus.mem_adr),
    .mem_wdata_o (bus.mem_wdata)
  );

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl with a behavioural 64x8 RAM (1-cycle read latency).
module tb_mem_seq_ctrl;

  logic Clk = 1'b0;
  logic Rst;
  int   total  = 0;
  int   passed = 0;
  int   n;
  logic [7:0] ram [64];

  mem_seq_ctrl_if #(.ADR_W(6), .DAT_W(8)) bus ();

  mem_seq_ctrl #(.ADR_W(6), .DAT_W(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  // RAM model.
  always @(posedge Clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_adr] <= bus.mem_wdata;
      else            bus.mem_rdata    <= ram[bus.mem_adr];
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_vld(output int cnt);
    cnt = 0;
    while (bus.cache_vld !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pulse_fwd();
    bus.forward = 1'b1;
    tick();
    bus.forward = 1'b0;
  endtask

  initial begin
    Rst = 1'b1;
    bus.wr_req  = 1'b1;
    bus.wr_adr  = 6'd0;
    bus.wr_data = 8'd0;
    bus.start   = 1'b0;
    bus.forward = 1'b0;
    tick();
    tick();
    check("rst_cache", bus.cache, 24'h000000);
    check("rst_vld", bus.cache_vld, 1'b0);
    check("rst_fin", bus.fin, 1'b0);
    check("rst_grp", bus.grp_idx, 5'd0);
    check("rst_wr_ack", bus.wr_ack, 1'b0);
    check("rst_mem_en", bus.mem_en, 1'b0);
    Rst = 1'b0;

    for (int a = 0; a < 64; a++) begin
      bus.wr_adr  = 6'(a);
      bus.wr_data = 8'(a);
      #1;
      check("load_ack", bus.wr_ack, 1'b1);
      tick();
    end
    bus.wr_req = 1'b0;
    check("ram0", ram[0], 8'h00);
    check("ram31", ram[31], 8'h1F);
    check("ram63", ram[63], 8'h3F);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rd0_adr", bus.mem_adr, 6'd0);
    check("rd0_we", bus.mem_we, 1'b0);
    wait_vld(n);
    check("lat_g0", n, 4);
    check("cache_g0", bus.cache, 24'h020100);
    check("grp_g0", bus.grp_idx, 5'd0);

    pulse_fwd();
    wait_vld(n);
    check("lat_g1", n, 4);
    check("cache_g1", bus.cache, 24'h050403);
    check("grp_g1", bus.grp_idx, 5'd1);

    for (int i = 2; i <= 20; i++) begin
      pulse_fwd();
      wait_vld(n);
    end
    check("cache_g20", bus.cache, 24'h3E3D3C);
    check("grp_g20", bus.grp_idx, 5'd20);

    pulse_fwd();
    check("done_fin", bus.fin, 1'b1);
    check("done_vld", bus.cache_vld, 1'b0);
    pulse_fwd();
    tick();
    check("done_hold_fin", bus.fin, 1'b1);
    check("done_mem_en", bus.mem_en, 1'b0);

    // Write granted with start, then held through the fetch.
    bus.start   = 1'b1;
    bus.wr_req  = 1'b1;
    bus.wr_adr  = 6'd1;
    bus.wr_data = 8'hAA;
    #1;
    check("start_wr_ack", bus.wr_ack, 1'b1);
    tick();
    bus.start = 1'b0;
    check("restart_fin", bus.fin, 1'b0);
    check("stall_rd0", bus.wr_ack, 1'b0);
    check("stall_rd0_adr", bus.mem_adr, 6'd0);
    tick();
    check("stall_rd1", bus.wr_ack, 1'b0);
    check("stall_rd1_adr", bus.mem_adr, 6'd1);
    tick();
    check("stall_rd2", bus.wr_ack, 1'b0);
    tick();
    check("grant_rd3", bus.wr_ack, 1'b1);
    check("grant_rd3_we", bus.mem_we, 1'b1);
    check("grant_rd3_adr", bus.mem_adr, 6'd1);
    tick();
    bus.wr_req = 1'b0;
    check("coh_vld", bus.cache_vld, 1'b1);
    check("coh_cache", bus.cache, 24'h02AA00);
    check("coh_ram1", ram[1], 8'hAA);

    bus.wr_req  = 1'b1;
    bus.wr_adr  = 6'd0;
    bus.wr_data = 8'h77;
    #1;
    check("valid_wr_ack", bus.wr_ack, 1'b1);
    tick();
    bus.wr_req = 1'b0;
    check("valid_cache_keep", bus.cache, 24'h02AA00);
    check("valid_ram0", ram[0], 8'h77);

    for (int i = 1; i <= 10; i++) begin
      pulse_fwd();
      wait_vld(n);
    end
    check("cache_g10", bus.cache, 24'h201F1E);
    check("grp_g10", bus.grp_idx, 5'd10);

    bus.start   = 1'b1;
    bus.forward = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.forward = 1'b0;
    check("sf_grp", bus.grp_idx, 5'd0);
    check("sf_vld", bus.cache_vld, 1'b0);
    check("sf_adr", bus.mem_adr, 6'd0);
    wait_vld(n);
    check("sf_lat", n, 4);
    check("sf_cache", bus.cache, 24'h02AA77);

    // Reset while in RD1.
    pulse_fwd();
    tick();
    check("pre_rst_rd1", bus.mem_adr, 6'd4);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("mid_rst_cache", bus.cache, 24'h000000);
    check("mid_rst_vld", bus.cache_vld, 1'b0);
    check("mid_rst_fin", bus.fin, 1'b0);
    check("mid_rst_grp", bus.grp_idx, 5'd0);
    check("mid_rst_mem_en", bus.mem_en, 1'b0);

    pulse_fwd();
    check("idle_fwd_ign", bus.mem_en, 1'b0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_ign_rd2", bus.mem_adr, 6'd2);
    wait_vld(n);
    check("start_ign_lat", n, 2);
    check("post_rst_cache", bus.cache, 24'h02AA77);
    check("post_rst_grp", bus.grp_idx, 5'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
